// File: rtl/sequence_recorder.sv
// Records a sequence of random symbols, plays it back with hold/gap timing,
// then checks the player's guesses against the stored sequence.
module sequence_recorder #(
  parameter int N           = 3,
  parameter int DEPTH       = 16,
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       append,
  input  logic                       play,
  input  logic [N-1:0]               random_value,
  output logic                       random_enable,
  output logic                       show_valid,
  output logic [N-1:0]               show_value,
  input  logic                       guess_valid,
  input  logic [N-1:0]               guess_value,
  output logic [$clog2(DEPTH+1)-1:0] length,
  output logic                       full,
  output logic                       busy,
  output logic                       checking,
  output logic                       round_ok,
  output logic                       round_fail
);

  localparam int LW   = $clog2(DEPTH + 1);
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CMAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

  typedef enum logic [1:0] {IDLE, SHOW, GAP, CHECK} state_t;

  state_t         state_q;
  logic [LW-1:0]  length_q;
  logic [AW-1:0]  index_q;
  logic [CW-1:0]  cnt_q;
  logic           random_enable_q;
  logic           show_valid_q;
  logic [N-1:0]   show_value_q;
  logic           round_ok_q;
  logic           round_fail_q;

  logic [N-1:0]   mem [DEPTH];

  logic           full_w;
  logic           append_ok;
  logic           at_last;

  assign full_w    = (length_q == LW'(DEPTH));
  assign append_ok = (state_q == IDLE) && !clear && append && !full_w;
  assign at_last   = (LW'(index_q) == (length_q - LW'(1)));

  // Symbol storage is never reset; only entries below length are ever read.
  always_ff @(posedge clock) begin
    if (append_ok) mem[length_q[AW-1:0]] <= random_value;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      length_q        <= '0;
      index_q         <= '0;
      cnt_q           <= '0;
      random_enable_q <= 1'b0;
      show_valid_q    <= 1'b0;
      show_value_q    <= '0;
      round_ok_q      <= 1'b0;
      round_fail_q    <= 1'b0;
    end else begin
      random_enable_q <= 1'b0;
      round_ok_q      <= 1'b0;
      round_fail_q    <= 1'b0;
      if (clear) begin
        state_q      <= IDLE;
        length_q     <= '0;
        index_q      <= '0;
        cnt_q        <= '0;
        show_valid_q <= 1'b0;
        show_value_q <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            // append takes precedence; a simultaneous play is dropped
            if (append) begin
              if (!full_w) begin
                length_q        <= length_q + LW'(1);
                random_enable_q <= 1'b1;
              end
            end else if (play && (length_q != '0)) begin
              state_q      <= SHOW;
              index_q      <= '0;
              cnt_q        <= '0;
              show_valid_q <= 1'b1;
              show_value_q <= mem[0];
            end
          end
          SHOW: begin
            if (cnt_q == CW'(HOLD_CYCLES - 1)) begin
              state_q      <= GAP;
              cnt_q        <= '0;
              show_valid_q <= 1'b0;
              show_value_q <= '0;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          GAP: begin
            if (cnt_q == CW'(GAP_CYCLES - 1)) begin
              cnt_q <= '0;
              if (at_last) begin
                state_q <= CHECK;
                index_q <= '0;
              end else begin
                state_q      <= SHOW;
                index_q      <= index_q + AW'(1);
                show_valid_q <= 1'b1;
                show_value_q <= mem[index_q + AW'(1)];
              end
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          CHECK: begin
            if (guess_valid) begin
              if (guess_value == mem[index_q]) begin
                if (at_last) begin
                  round_ok_q <= 1'b1;
                  state_q    <= IDLE;
                  index_q    <= '0;
                end else begin
                  index_q <= index_q + AW'(1);
                end
              end else begin
                round_fail_q <= 1'b1;
                length_q     <= '0;
                state_q      <= IDLE;
                index_q      <= '0;
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign random_enable = random_enable_q;
  assign show_valid    = show_valid_q;
  assign show_value    = show_value_q;
  assign length        = length_q;
  assign full          = full_w;
  assign busy          = (state_q != IDLE);
  assign checking      = (state_q == CHECK);
  assign round_ok      = round_ok_q;
  assign round_fail    = round_fail_q;

endmodule

// File: tb/tb_sequence_recorder.sv
// Vector-table bench for sequence_recorder: each record carries one cycle of
// inputs plus the outputs expected right after the following rising edge.
module tb_sequence_recorder;

  localparam int N     = 3;
  localparam int DEPTH = 16;
  localparam int LW    = $clog2(DEPTH + 1);

  logic          clock = 1'b0;
  logic          reset;
  logic          clear;
  logic          append;
  logic          play;
  logic [N-1:0]  random_value;
  logic          guess_valid;
  logic [N-1:0]  guess_value;
  logic          random_enable;
  logic          show_valid;
  logic [N-1:0]  show_value;
  logic [LW-1:0] length;
  logic          full;
  logic          busy;
  logic          checking;
  logic          round_ok;
  logic          round_fail;

  sequence_recorder #(.N(N), .DEPTH(DEPTH), .HOLD_CYCLES(4), .GAP_CYCLES(2)) dut (
    .clock        (clock),
    .reset        (reset),
    .clear        (clear),
    .append       (append),
    .play         (play),
    .random_value (random_value),
    .random_enable(random_enable),
    .show_valid   (show_valid),
    .show_value   (show_value),
    .guess_valid  (guess_valid),
    .guess_value  (guess_value),
    .length       (length),
    .full         (full),
    .busy         (busy),
    .checking     (checking),
    .round_ok     (round_ok),
    .round_fail   (round_fail)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic          clr, app, ply;
    logic [N-1:0]  rv;
    logic          gv;
    logic [N-1:0]  gval;
    logic [LW-1:0] len;
    logic          ful, bsy, chk, ok, fail, ren, sv;
    logic [N-1:0]  sval;
  } vec_t;

  vec_t table_q[$];
  vec_t sb_q[$];
  int   errors = 0;
  int   checks = 0;
  int   vec_no = 0;

  function automatic vec_t mk(input int clr, app, ply, rv, gv, gval,
                              input int len, ful, bsy, chk, ok, fail, ren, sv, sval);
    vec_t v;
    v.clr = 1'(clr);  v.app = 1'(app);  v.ply = 1'(ply);
    v.rv  = N'(rv);   v.gv  = 1'(gv);   v.gval = N'(gval);
    v.len = LW'(len); v.ful = 1'(ful);  v.bsy = 1'(bsy);  v.chk = 1'(chk);
    v.ok  = 1'(ok);   v.fail = 1'(fail); v.ren = 1'(ren); v.sv = 1'(sv);
    v.sval = N'(sval);
    return v;
  endfunction

  task automatic chk_field(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s at vec %0d: got %0d, expected %0d", name, vec_no, act, exp_v);
    end
  endtask

  task automatic check_outputs(input vec_t e);
    chk_field("length",        32'(length),        32'(e.len));
    chk_field("full",          32'(full),          32'(e.ful));
    chk_field("busy",          32'(busy),          32'(e.bsy));
    chk_field("checking",      32'(checking),      32'(e.chk));
    chk_field("round_ok",      32'(round_ok),      32'(e.ok));
    chk_field("round_fail",    32'(round_fail),    32'(e.fail));
    chk_field("random_enable", 32'(random_enable), 32'(e.ren));
    chk_field("show_valid",    32'(show_valid),    32'(e.sv));
    chk_field("show_value",    32'(show_value),    32'(e.sval));
  endtask

  // Drive one cycle of inputs, queue its expectation, compare after the edge.
  task automatic apply(input vec_t v);
    vec_t e;
    clear = v.clr; append = v.app; play = v.ply; random_value = v.rv;
    guess_valid = v.gv; guess_value = v.gval;
    sb_q.push_back(v);
    @(posedge clock);
    #1;
    e = sb_q.pop_front();
    check_outputs(e);
    $display("vec %0d: clr=%0b app=%0b ply=%0b gv=%0b -> len=%0d busy=%0b chk=%0b sv=%0b val=%0d ok=%0b fail=%0b ren=%0b",
             vec_no, v.clr, v.app, v.ply, v.gv, length, busy, checking,
             show_valid, show_value, round_ok, round_fail, random_enable);
    vec_no++;
  endtask

  task automatic run_table();
    while (table_q.size() > 0) apply(table_q.pop_front());
  endtask

  // Playback of L symbols: 4 shown + 2 blank cycles per symbol, then CHECK.
  // Stray append/guess/play inputs are injected mid-playback and must be ignored.
  task automatic add_play(input int s0, s1, s2, input int L, input int len);
    for (int k = 1; k <= L * 6 + 1; k++) begin
      int pos, slot, sym, sv, sval, chk;
      pos  = (k - 1) % 6;
      slot = (k - 1) / 6;
      sym  = (slot == 0) ? s0 : (slot == 1) ? s1 : s2;
      if (k <= L * 6) begin
        sv = (pos < 4) ? 1 : 0;
        sval = (sv != 0) ? sym : 0;
        chk = 0;
      end else begin
        sv = 0; sval = 0; chk = 1;
      end
      table_q.push_back(mk(0, (k == 3) ? 1 : 0, (k == 1 || k == 11) ? 1 : 0, k % 8,
                           (k == 9) ? 1 : 0, s0,
                           len, 0, 1, chk, 0, 0, 0, sv, sval));
    end
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; append = 1'b0; play = 1'b0;
    random_value = '0; guess_valid = 1'b0; guess_value = '0;
    repeat (2) @(posedge clock);
    #1;
    check_outputs(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    reset = 1'b0;

    // clr app ply rv gv gval | len full busy chk ok fail ren sv sval
    table_q.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0));
    table_q.push_back(mk(0, 1, 0, 5, 0, 0,  1, 0, 0, 0, 0, 0, 1, 0, 0));
    table_q.push_back(mk(0, 1, 0, 2, 0, 0,  2, 0, 0, 0, 0, 0, 1, 0, 0));
    table_q.push_back(mk(0, 1, 0, 7, 0, 0,  3, 0, 0, 0, 0, 0, 1, 0, 0));
    table_q.push_back(mk(0, 0, 0, 1, 0, 0,  3, 0, 0, 0, 0, 0, 0, 0, 0));
    table_q.push_back(mk(0, 0, 0, 1, 1, 5,  3, 0, 0, 0, 0, 0, 0, 0, 0));
    add_play(5, 2, 7, 3, 3);
    table_q.push_back(mk(0, 0, 0, 0, 1, 5,  3, 0, 1, 1, 0, 0, 0, 0, 0));
    table_q.push_back(mk(0, 0, 0, 0, 0, 2,  3, 0, 1, 1, 0, 0, 0, 0, 0));
    table_q.push_back(mk(0, 0, 0, 0, 1, 2,  3, 0, 1, 1, 0, 0, 0, 0, 0));
    table_q.push_back(mk(0, 0, 0, 0, 1, 7,  3, 0, 0, 0, 1, 0, 0, 0, 0));
    table_q.push_back(mk(0, 0, 0, 0, 0, 0,  3, 0, 0, 0, 0, 0, 0, 0, 0));
    add_play(5, 2, 7, 3, 3);
    table_q.push_back(mk(0, 0, 0, 0, 1, 5,  3, 0, 1, 1, 0, 0, 0, 0, 0));
    table_q.push_back(mk(0, 0, 0, 0, 1, 3,  0, 0, 0, 0, 0, 1, 0, 0, 0));
    table_q.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0));
    // append wins over a simultaneous play; stored content checked by replay
    table_q.push_back(mk(0, 1, 0, 1, 0, 0,  1, 0, 0, 0, 0, 0, 1, 0, 0));
    table_q.push_back(mk(0, 1, 0, 4, 0, 0,  2, 0, 0, 0, 0, 0, 1, 0, 0));
    table_q.push_back(mk(0, 1, 1, 6, 0, 0,  3, 0, 0, 0, 0, 0, 1, 0, 0));
    table_q.push_back(mk(0, 0, 0, 0, 0, 0,  3, 0, 0, 0, 0, 0, 0, 0, 0));
    add_play(1, 4, 6, 3, 3);
    table_q.push_back(mk(0, 0, 0, 0, 1, 1,  3, 0, 1, 1, 0, 0, 0, 0, 0));
    table_q.push_back(mk(0, 0, 0, 0, 1, 4,  3, 0, 1, 1, 0, 0, 0, 0, 0));
    table_q.push_back(mk(0, 0, 0, 0, 1, 6,  3, 0, 0, 0, 1, 0, 0, 0, 0));
    // clear in IDLE, then play with an empty sequence
    table_q.push_back(mk(1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0));
    table_q.push_back(mk(0, 0, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0));
    table_q.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0));
    // clear during SHOW, with a guess in the same cycle
    table_q.push_back(mk(0, 1, 0, 3, 0, 0,  1, 0, 0, 0, 0, 0, 1, 0, 0));
    table_q.push_back(mk(0, 0, 1, 0, 0, 0,  1, 0, 1, 0, 0, 0, 0, 1, 3));
    table_q.push_back(mk(0, 0, 0, 0, 0, 0,  1, 0, 1, 0, 0, 0, 0, 1, 3));
    table_q.push_back(mk(1, 0, 0, 0, 1, 3,  0, 0, 0, 0, 0, 0, 0, 0, 0));
    table_q.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0));
    run_table();

    // fill to DEPTH, then one more append must be ignored
    for (int i = 0; i < DEPTH; i++)
      apply(mk(0, 1, 0, i % 8, 0, 0, i + 1, (i == DEPTH - 1) ? 1 : 0, 0, 0, 0, 0, 1, 0, 0));
    apply(mk(0, 1, 0, 3, 0, 0, DEPTH, 1, 0, 0, 0, 0, 0, 0, 0));
    apply(mk(0, 0, 0, 0, 0, 0, DEPTH, 1, 0, 0, 0, 0, 0, 0, 0));
    apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    // reset asserted in CHECK together with the deciding (correct) guess
    apply(mk(0, 1, 0, 6, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0));
    add_play(6, 0, 0, 1, 1);
    run_table();
    guess_valid = 1'b1;
    guess_value = 3'd6;
    #2;
    reset = 1'b1;
    #1;
    check_outputs(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clock);
    #1;
    check_outputs(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    guess_valid = 1'b0;
    reset = 1'b0;
    apply(mk(0, 0, 0, 0, 1, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
